// File: rtl/pwr_up_seq_if.sv
// Sequencer handshake bundle: power-down request and sensor ready in, sub-system
// reset/enable controls and status out.
interface pwr_up_seq_if;
  logic pwr_off;
  logic sns_rdy;
  logic sns_rst_n;
  logic ctrl_rst_n;
  logic mtr_en;
  logic seq_done;
  logic seq_fault;

  // master: the side that requests power state and sees the resets
  modport master (
    output pwr_off,
    output sns_rdy,
    input  sns_rst_n,
    input  ctrl_rst_n,
    input  mtr_en,
    input  seq_done,
    input  seq_fault
  );

  // slave: the sequencer itself
  modport slave (
    input  pwr_off,
    input  sns_rdy,
    output sns_rst_n,
    output ctrl_rst_n,
    output mtr_en,
    output seq_done,
    output seq_fault
  );
endinterface

// File: rtl/pwr_up_seq.sv
// Power-up/down sequencer: releases sensor, controller, motor in order and tears
// them down in reverse; sensor-init timeout or loss of sensor ready latches FAULT.
module pwr_up_seq #(
  parameter int unsigned CNT_W    = 20,
  parameter int unsigned STG_DLY  = 4,
  parameter int unsigned INIT_TMO = 16
) (
  input logic         clk,
  input logic         rst_n,
  pwr_up_seq_if.slave bus
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] SNS_REL  = 4'd1;
  localparam logic [3:0] SNS_WAIT = 4'd2;
  localparam logic [3:0] CTRL_REL = 4'd3;
  localparam logic [3:0] RUN      = 4'd4;
  localparam logic [3:0] SHD_CTRL = 4'd5;
  localparam logic [3:0] SHD_SNS  = 4'd6;
  localparam logic [3:0] OFF      = 4'd7;
  localparam logic [3:0] FAULT    = 4'd8;

  localparam logic [CNT_W-1:0] STG_LAST = CNT_W'(STG_DLY - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(INIT_TMO - 1);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stg_done, tmo_done, timed;

  assign stg_done = (cnt_q == STG_LAST);
  assign tmo_done = (cnt_q == TMO_LAST);

  always_comb begin
    timed = 1'b0;
    case (state_q)
      SNS_REL, SNS_WAIT, CTRL_REL, SHD_CTRL, SHD_SNS: timed = 1'b1;
      default:                                        timed = 1'b0;
    endcase
  end

  // Within each state the if/else order is the transition priority.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!bus.pwr_off) state_d = SNS_REL;
      end
      SNS_REL: begin
        if (bus.pwr_off)   state_d = SHD_SNS;
        else if (stg_done) state_d = SNS_WAIT;
      end
      SNS_WAIT: begin
        if (bus.pwr_off)      state_d = SHD_SNS;
        else if (bus.sns_rdy) state_d = CTRL_REL;
        else if (tmo_done)    state_d = FAULT;
      end
      CTRL_REL: begin
        if (bus.pwr_off)   state_d = SHD_CTRL;
        else if (stg_done) state_d = RUN;
      end
      RUN: begin
        if (bus.pwr_off)       state_d = SHD_CTRL;
        else if (!bus.sns_rdy) state_d = FAULT;
      end
      SHD_CTRL: begin
        if (stg_done) state_d = SHD_SNS;
      end
      SHD_SNS: begin
        if (stg_done) state_d = OFF;
      end
      OFF: begin
        if (!bus.pwr_off) state_d = IDLE;
      end
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase
  end

  // Counter saturates rather than wrapping if a state ever overstays.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (timed && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  logic sns_rst_n, ctrl_rst_n, mtr_en, seq_done, seq_fault;

  always_comb begin
    sns_rst_n  = 1'b0;
    ctrl_rst_n = 1'b0;
    mtr_en     = 1'b0;
    seq_done   = 1'b0;
    seq_fault  = 1'b0;
    case (state_q)
      SNS_REL, SNS_WAIT, SHD_SNS: sns_rst_n = 1'b1;
      CTRL_REL, SHD_CTRL: begin
        sns_rst_n  = 1'b1;
        ctrl_rst_n = 1'b1;
      end
      RUN: begin
        sns_rst_n  = 1'b1;
        ctrl_rst_n = 1'b1;
        mtr_en     = 1'b1;
        seq_done   = 1'b1;
      end
      FAULT:   seq_fault = 1'b1;
      default: ;
    endcase
  end

  assign bus.sns_rst_n  = sns_rst_n;
  assign bus.ctrl_rst_n = ctrl_rst_n;
  assign bus.mtr_en     = mtr_en;
  assign bus.seq_done   = seq_done;
  assign bus.seq_fault  = seq_fault;

endmodule

// File: tb/tb_pwr_up_seq.sv
// Randomized bench for pwr_up_seq against a phase/age reference model.
module tb_pwr_up_seq;
  localparam int unsigned STG_DLY  = 4;
  localparam int unsigned INIT_TMO = 16;

  logic clk;
  logic rst_n;
  pwr_up_seq_if bus ();

  pwr_up_seq #(
    .CNT_W    (20),
    .STG_DLY  (STG_DLY),
    .INIT_TMO (INIT_TMO)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model phases in sequence order; outputs come from a lookup table.
  localparam int P_IDLE = 0, P_SREL = 1, P_SWAIT = 2, P_CREL = 3, P_RUN = 4;
  localparam int P_SHDC = 5, P_SHDS = 6, P_OFF = 7, P_FAULT = 8;
  // {sns_rst_n, ctrl_rst_n, mtr_en, seq_done, seq_fault}
  logic [4:0] out_tbl [9] = '{5'b00000, 5'b10000, 5'b10000, 5'b11000, 5'b11110,
                              5'b11000, 5'b10000, 5'b00000, 5'b00001};

  int m_phase;
  int m_age;
  int n_total;
  int n_bad;

  function automatic logic [4:0] dut_outs();
    return {bus.sns_rst_n, bus.ctrl_rst_n, bus.mtr_en, bus.seq_done, bus.seq_fault};
  endfunction

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%b want=%b (phase=%0d age=%0d t=%0t)",
               tag, got, exp, m_phase, m_age, $time);
    end
  endtask

  task automatic m_step(input bit po, input bit rdy);
    int nxt;
    bit stg_up, tmo_up;
    stg_up = (m_age >= int'(STG_DLY) - 1);
    tmo_up = (m_age >= int'(INIT_TMO) - 1);
    nxt = m_phase;
    case (m_phase)
      P_IDLE:  if (!po) nxt = P_SREL;
      P_SREL:  nxt = po ? P_SHDS : (stg_up ? P_SWAIT : P_SREL);
      P_SWAIT: nxt = po ? P_SHDS : (rdy ? P_CREL : (tmo_up ? P_FAULT : P_SWAIT));
      P_CREL:  nxt = po ? P_SHDC : (stg_up ? P_RUN : P_CREL);
      P_RUN:   nxt = po ? P_SHDC : (!rdy ? P_FAULT : P_RUN);
      P_SHDC:  if (stg_up) nxt = P_SHDS;
      P_SHDS:  if (stg_up) nxt = P_OFF;
      P_OFF:   if (!po) nxt = P_IDLE;
      default: nxt = P_FAULT;
    endcase
    m_age   = (nxt != m_phase) ? 0 : m_age + 1;
    m_phase = nxt;
  endtask

  // Entered at a negedge; leaves at a later negedge with rst_n released.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1 check("async_rst", dut_outs(), 5'b00000);
    m_phase = P_IDLE;
    m_age   = 0;
    @(posedge clk);
    #1 check("rst_hold", dut_outs(), 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int mode, po_hold, rst_at;
  bit po, rdy;

  initial begin
    n_total = 0;
    n_bad   = 0;
    m_phase = P_IDLE;
    m_age   = 0;
    rst_n   = 1'b0;
    bus.pwr_off = 1'b0;
    bus.sns_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_state", dut_outs(), 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;

    for (int ep = 0; ep < 48; ep++) begin
      // First four episodes are fixed: clean power-up, timeout, boundary, random.
      mode    = (ep < 4) ? ep : int'($urandom_range(0, 3));
      po_hold = 0;
      rst_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 40)) : -1;
      for (int cyc = 0; cyc < 60; cyc++) begin
        if (cyc == rst_at) async_reset();
        case (mode)
          0: begin
            if (po_hold > 0) po_hold--;
            else if ($urandom_range(0, 39) == 0) po_hold = int'($urandom_range(1, 14));
            po  = (po_hold > 0);
            rdy = ($urandom_range(0, 59) != 0);
          end
          1: begin
            po  = (m_phase == P_FAULT) ? bit'($urandom_range(0, 1)) : 1'b0;
            rdy = (m_phase == P_FAULT) ? bit'($urandom_range(0, 1)) : 1'b0;
          end
          2: begin
            // sensor ready arrives exactly on the last permitted SNS_WAIT cycle
            po  = 1'b0;
            rdy = (m_phase > P_SWAIT) ||
                  (m_phase == P_SWAIT && m_age == int'(INIT_TMO) - 1);
          end
          default: begin
            po  = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 3) != 0);
          end
        endcase
        bus.pwr_off = po;
        bus.sns_rdy = rdy;
        #1 check("moore_hold", dut_outs(), out_tbl[m_phase]);
        @(posedge clk);
        m_step(po, rdy);
        #1 check($sformatf("step_m%0d", mode), dut_outs(), out_tbl[m_phase]);
        @(negedge clk);
      end
      async_reset();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
